// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared types and sizing helpers for the FIFO-draining UART transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro used by importers: FIFO_UART_TX_PARITY_EN.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  // Line level while no frame is being sent (also the stop-bit level).
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for a counter running 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int BAUD_CNT_W_DEFAULT = cnt_width(16);
  localparam int BIT_CNT_W_DEFAULT  = cnt_width(8);

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// baud_tick_gen: free-running bit-period counter producing a one-cycle bit_end tick.
// Latency: bit_end in the CLKS_PER_BIT-th cycle after clear is released.
// Backpressure: none; clear holds the counter at zero and suppresses the tick.
// Ports: clk, reset (sync, active-high), clear (hold at 0), bit_end (last cycle of a bit period).
module baud_tick_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = !clear && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO read port and serialises them as UART frames (start, data LSB first, [parity], stop).
// Latency: rd_en one cycle after tx_en is seen in IDLE, start bit two cycles after rd_en.
// Backpressure: an empty FIFO (rd_val=0) returns to IDLE and re-polls every 3 cycles while tx_en is high.
// Ports: clk, reset (sync, active-high), tx_en (fetch enable), rd_en/rd_data/rd_val (FIFO read port),
//        tx (serial line, idle high), busy (frame on line), done (last cycle of frame).
// Optional: define FIFO_UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_val,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int BIT_CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_t                 state;
  state_t                 state_next;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   stop_cnt;
  logic                   bit_end;
  logic                   baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                   parity_bit;
`endif

  // Baud counter idles at zero outside a frame, so it starts cleanly on entry to START.
  assign baud_clear = !busy;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    tx         = IDLE_LEVEL;
    case (state)
      IDLE: begin
        if (tx_en) state_next = REQ;
      end
      REQ: begin
        rd_en      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        state_next = rd_val ? START : IDLE;
      end
      START: begin
        busy = 1'b1;
        tx   = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        busy = 1'b1;
        tx   = shreg[0];
        if (bit_end && (bit_cnt == LAST_BIT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        busy = 1'b1;
        tx   = parity_bit;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        busy = 1'b1;
        if (bit_end && (stop_cnt == STOP_LAST)) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: word capture, data shifting, bit and stop-bit counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT: begin
          if (rd_val) begin
            shreg    <= rd_data;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= ^rd_data;
`endif
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            stop_cnt <= (stop_cnt == STOP_LAST) ? 1'b0 : stop_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PB = 1;
  localparam int FRAME_CYCLES_REQ = 44;
`else
  localparam int PB = 0;
  localparam int FRAME_CYCLES_REQ = 40;
`endif
  localparam int NBITS = 1 + DW + SB + PB;
  localparam int FL    = NBITS * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_en;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_val;
  logic          tx;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tx_en  (tx_en),
    .rd_en  (rd_en),
    .rd_data(rd_data),
    .rd_val (rd_val),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] fq[$];   // words held by the FIFO responder
  logic [DW-1:0] mq[$];   // same words as seen by the reference model
  bit exp_tx[$];
  bit exp_rd[$];
  bit exp_busy[$];
  bit exp_done[$];

  int rd_cnt;
  int busy_cnt;
  int gap;

  // FIFO responder: answers a read request on the cycle after rd_en, with junk otherwise.
  initial begin : fifo_resp
    logic prev;
    prev    = 1'b0;
    rd_val  = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (prev && fq.size() > 0) begin
        rd_val  = 1'b1;
        rd_data = fq.pop_front();
      end else begin
        rd_val  = prev ? 1'b0 : 1'($urandom_range(0, 1));
        rd_data = DW'($urandom);
      end
      prev = rd_en;
    end
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    mq.push_back(w);
  endtask

  task automatic emit(input bit t, input bit r, input bit b, input bit d);
    exp_tx.push_back(t);
    exp_rd.push_back(r);
    exp_busy.push_back(b);
    exp_done.push_back(d);
  endtask

  // Reference timeline: tx_en looked at once per poll; each poll is IDLE, REQ, WAIT,
  // followed by a full frame when a word is available.
  task automatic build(input int n, input int drop);
    int c;
    logic [DW-1:0] w;
    bit lvl;
    exp_tx.delete(); exp_rd.delete(); exp_busy.delete(); exp_done.delete();
    c = 0;
    while (c < n) begin
      if (c >= drop) begin
        emit(1'b1, 1'b0, 1'b0, 1'b0);
        c++;
      end else begin
        emit(1'b1, 1'b0, 1'b0, 1'b0);
        emit(1'b1, 1'b1, 1'b0, 1'b0);
        emit(1'b1, 1'b0, 1'b0, 1'b0);
        c += 3;
        if (mq.size() > 0) begin
          w = mq.pop_front();
          for (int k = 0; k < NBITS; k++) begin
            if (k == 0)                   lvl = 1'b0;
            else if (k <= DW)             lvl = w[k-1];
            else if (PB == 1 && k == DW + 1) lvl = ^w;
            else                          lvl = 1'b1;
            for (int j = 0; j < CPB; j++)
              emit(lvl, 1'b0, 1'b1, (k == NBITS - 1) && (j == CPB - 1));
          end
          c += FL;
        end
      end
    end
  endtask

  // Compares n consecutive cycles; cycle 0 is the first negedge after the call.
  task automatic run(input int n, input int drop, input string tag);
    int  dc;
    bit  pb;
    build(n, drop);
    rd_cnt   = 0;
    busy_cnt = 0;
    gap      = -1;
    dc       = -1;
    pb       = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tx_en = (c < drop);
      check1($sformatf("%s.tx@%0d", tag, c), tx, exp_tx[c]);
      check1($sformatf("%s.rd_en@%0d", tag, c), rd_en, exp_rd[c]);
      check1($sformatf("%s.busy@%0d", tag, c), busy, exp_busy[c]);
      check1($sformatf("%s.done@%0d", tag, c), done, exp_done[c]);
      if (rd_en === 1'b1) rd_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && !pb && dc >= 0 && gap < 0) gap = c - dc - 1;
      if (done === 1'b1) dc = c;
      pb = (busy === 1'b1);
    end
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    check1({tag, ".idle_tx"}, tx, 1'b1);
    check1({tag, ".idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    tx_en = 1'b0;

    // Reset state and no fetching while tx_en is low.
    repeat (3) @(negedge clk);
    check1("reset.tx", tx, 1'b1);
    check1("reset.rd_en", rd_en, 1'b0);
    check1("reset.busy", busy, 1'b0);
    check1("reset.done", done, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1($sformatf("hold.rd_en@%0d", i), rd_en, 1'b0);
      check1($sformatf("hold.tx@%0d", i), tx, 1'b1);
    end

    // Single frame 0xA5.
    push_word(8'hA5);
    run(3 + FL, 3 + FL, "a5");
    checkn("a5.rd_pulses", rd_cnt, 1);
    checkn("a5.frame_len", busy_cnt, FL);
    settle("a5");

    // Empty FIFO: poll every 3 cycles, never busy.
    run(12, 12, "empty");
    checkn("empty.rd_pulses", rd_cnt, 4);
    checkn("empty.busy_cycles", busy_cnt, 0);
    settle("empty");

    // Back-to-back 0x00 then 0xFF.
    push_word(8'h00);
    push_word(8'hFF);
    run(2 * (3 + FL), 2 * (3 + FL), "b2b");
    checkn("b2b.rd_pulses", rd_cnt, 2);
    checkn("b2b.idle_gap", gap, 3);
    settle("b2b");

    // Reset during the third data bit of 0x5A; 0x3C must follow as a fresh fetch.
    push_word(8'h5A);
    push_word(8'h3C);
    run(17, 100, "rst_pre");
    reset = 1'b1;
    @(negedge clk);
    check1("rst.tx", tx, 1'b1);
    check1("rst.busy", busy, 1'b0);
    check1("rst.done", done, 1'b0);
    reset = 1'b0;
    tx_en = 1'b0;
    run(3 + FL, 3 + FL, "rst_post");
    checkn("rst_post.rd_pulses", rd_cnt, 1);
    settle("rst_post");

    // Parity/frame-length word 0x07.
    push_word(8'h07);
    run(3 + FL, 3 + FL, "w07");
    checkn("w07.frame_len", busy_cnt, FRAME_CYCLES_REQ);
    settle("w07");

    // tx_en drops mid-frame: the frame finishes, nothing else is fetched.
    push_word(8'($urandom));
    push_word(8'($urandom));
    run(3 + FL + 20, 10, "drop");
    checkn("drop.rd_pulses", rd_cnt, 1);
    checkn("drop.frame_len", busy_cnt, FL);
    settle("drop");

    // Random words, including the one left over from the previous step.
    for (int i = 0; i < 3; i++) push_word(8'($urandom));
    run(4 * (3 + FL), 4 * (3 + FL), "rand");
    checkn("rand.rd_pulses", rd_cnt, 4);
    checkn("rand.busy_cycles", busy_cnt, 4 * FL);
    settle("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
